// File: rtl/signed_seq_divider.sv
// signed_seq_divider: iterative signed divider, 2*width-bit dividend by
// width-bit divisor, with a radix-2 restoring core on magnitudes and a
// final sign fix-up cycle. Uses the same enable/busy/done handshake as the
// multiplier wrapper, so either block can sit behind one controller.
//
// Optional build macro SDIV_DIVZERO_FLAG_EN adds a registered div_by_zero
// output that is updated together with q/r.
//
// state   | meaning
// --------+-------------------------------------------------------------
// st_idle | waiting for enable; q/r/div_by_zero hold the last result
// st_calc | 2*width restoring iterations, one quotient bit per cycle
// st_sign | apply result signs, register q/r, pulse done
module signed_seq_divider #(
  parameter int width = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*width-1:0]   ab,
  input  logic [width-1:0]     b,
  input  logic                 enable,
  output logic [2*width-1:0]   q,
  output logic [width-1:0]     r,
  output logic                 busy,
  output logic                 done
`ifdef SDIV_DIVZERO_FLAG_EN
  ,
  output logic                 div_by_zero
`endif
);

  localparam int cw = $clog2(2*width);
  localparam logic [cw-1:0] last_count = cw'(2*width-1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_calc = 2'd1;
  localparam logic [1:0] st_sign = 2'd2;

  logic [1:0]         state;
  logic [cw-1:0]      count;
  // Holds |ab| at start; quotient bits shift in at the bottom, so after the
  // last iteration it holds the quotient magnitude.
  logic [2*width-1:0] dvd;
  logic [width-1:0]   bmag;
  // Partial remainder, width+1 bits wide.
  logic [width:0]     rem;
  logic               sign_q;
  logic               sign_r;
  logic               divzero;
  logic [width-1:0]   ab_low;

  logic [2*width-1:0] abmag_in;
  logic [width-1:0]   bmag_in;
  logic [width+1:0]   shifted;
  logic [width+1:0]   diff;
  logic               trial_ok;

  // Input magnitudes (most negative value reads back as 2^(n-1) unsigned)
  // and one restoring trial subtraction.
  always_comb begin
    abmag_in = ab[2*width-1] ? -ab : ab;
    bmag_in  = b[width-1] ? -b : b;
    shifted  = {rem, dvd[2*width-1]};
    diff     = shifted - {2'b00, bmag};
    trial_ok = ~diff[width+1];
  end

  assign busy = (state != st_idle);

  // Sequencing: start in idle, count iterations in calc, one cycle of sign.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= st_idle;
      count <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (enable) begin
            count <= '0;
            state <= st_calc;
          end
        end
        st_calc: begin
          count <= count + cw'(1);
          if (count == last_count) state <= st_sign;
        end
        st_sign: state <= st_idle;
        default: state <= st_idle;
      endcase
    end
  end

  // Operand latch at start and the restoring iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd     <= '0;
      bmag    <= '0;
      rem     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      divzero <= 1'b0;
      ab_low  <= '0;
    end else begin
      if (state == st_idle && enable) begin
        dvd     <= abmag_in;
        bmag    <= bmag_in;
        rem     <= '0;
        sign_q  <= ab[2*width-1] ^ b[width-1];
        sign_r  <= ab[2*width-1];
        divzero <= (b == '0);
        ab_low  <= ab[width-1:0];
      end else if (state == st_calc) begin
        dvd <= {dvd[2*width-2:0], trial_ok};
        rem <= trial_ok ? diff[width:0] : shifted[width:0];
      end
    end
  end

  // Result registers: signed fix-up and done pulse in the sign cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      r    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == st_sign) begin
        done <= 1'b1;
        if (divzero) begin
          q <= '1;
          r <= ab_low;
        end else begin
          q <= sign_q ? -dvd : dvd;
          r <= sign_r ? -rem[width-1:0] : rem[width-1:0];
        end
      end
    end
  end

`ifdef SDIV_DIVZERO_FLAG_EN
  // Divide-by-zero flag, updated alongside q/r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_by_zero <= 1'b0;
    else if (state == st_sign) div_by_zero <= divzero;
  end
`endif

endmodule

// File: tb/tb_signed_seq_divider.sv
// Testbench for signed_seq_divider at width=8 (16-bit dividend).
module tb_signed_seq_divider;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2*W-1:0]  ab = '0;
  logic [W-1:0]    b = '0;
  logic            enable = 1'b0;
  logic [2*W-1:0]  q;
  logic [W-1:0]    r;
  logic            busy;
  logic            done;
`ifdef SDIV_DIVZERO_FLAG_EN
  logic            div_by_zero;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  signed_seq_divider #(.width(W)) dut (
    .clk(clk),
    .reset(reset),
    .ab(ab),
    .b(b),
    .enable(enable),
    .q(q),
    .r(r),
    .busy(busy),
    .done(done)
`ifdef SDIV_DIVZERO_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain signed integer division (truncating, remainder takes
  // the dividend's sign), with the divide-by-zero convention.
  function automatic void model(input logic [15:0] a, input logic [7:0] d,
                                output logic [15:0] eq, output logic [7:0] er);
    int sa;
    int sd;
    sa = int'($signed(a));
    sd = int'($signed(d));
    if (d == 8'd0) begin
      eq = 16'hFFFF;
      er = a[7:0];
    end else begin
      eq = 16'(sa / sd);
      er = 8'(sa % sd);
    end
  endfunction

  function automatic logic flag_now();
`ifdef SDIV_DIVZERO_FLAG_EN
    return div_by_zero;
`else
    return 1'b0;
`endif
  endfunction

  // Start one op, scramble inputs after the start edge, wait for done.
  // lat = posedges after the start edge until done is seen (100 = timeout).
  task automatic run_op(input logic [15:0] a, input logic [7:0] d,
                        output logic [15:0] gq, output logic [7:0] gr,
                        output logic gz, output int lat);
    @(negedge clk);
    ab = a; b = d; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    ab = 16'($urandom);
    b  = 8'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    gq = q; gr = r; gz = flag_now();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    total_cnt++;
    if (q !== 16'h0 || r !== 8'h0 || busy !== 1'b0 || done !== 1'b0 || flag_now() !== 1'b0)
      $display("FAIL reset_state: q=%h r=%h busy=%b done=%b flag=%b, expected all zero",
               q, r, busy, done, flag_now());
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [15:0] gq; logic [7:0] gr; logic gz; int lat;
    run_op(16'd100, 8'd7, gq, gr, gz, lat);
    total_cnt++;
    if (lat !== 17) $display("FAIL basic_latency: got %0d expected 17", lat);
    else pass_cnt++;
    total_cnt++;
    if (gq !== 16'd14 || gr !== 8'd2)
      $display("FAIL basic_result: q=%h r=%h expected q=000e r=02", gq, gr);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b expected 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done);
    else pass_cnt++;
    total_cnt++;
    if (q !== 16'd14 || r !== 8'd2)
      $display("FAIL hold_in_idle: q=%h r=%h expected 000e 02", q, r);
    else pass_cnt++;
  endtask

  task automatic test_signs();
    logic [15:0] ta [5];
    logic [7:0]  tb [5];
    logic [15:0] xq [5];
    logic [7:0]  xr [5];
    logic [15:0] gq; logic [7:0] gr; logic gz; int lat;
    // -100/7, 100/-7, -100/-7, -32768/-1, 32767/-128
    ta = '{16'hFF9C, 16'd100, 16'hFF9C, 16'h8000, 16'h7FFF};
    tb = '{8'd7,     8'hF9,   8'hF9,    8'hFF,    8'h80};
    xq = '{16'hFFF2, 16'hFFF2, 16'd14,  16'h8000, 16'hFF01};
    xr = '{8'hFE,    8'h02,    8'hFE,   8'h00,    8'h7F};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], gq, gr, gz, lat);
      total_cnt++;
      if (gq !== xq[i] || gr !== xr[i] || lat !== 17)
        $display("FAIL signs_edges[%0d]: q=%h r=%h lat=%0d expected q=%h r=%h lat=17",
                 i, gq, gr, lat, xq[i], xr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_divzero();
    logic [15:0] ta [3];
    logic [7:0]  tb [3];
    logic [15:0] xq [3];
    logic [7:0]  xr [3];
    logic        xz [3];
    logic [15:0] gq; logic [7:0] gr; logic gz; int lat;
    ta = '{16'h1234, 16'hF234, 16'd100};
    tb = '{8'h00,    8'h00,    8'd7};
    xq = '{16'hFFFF, 16'hFFFF, 16'd14};
    xr = '{8'h34,    8'h34,    8'h02};
    xz = '{1'b1,     1'b1,     1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], gq, gr, gz, lat);
      total_cnt++;
      if (gq !== xq[i] || gr !== xr[i] || lat !== 17)
        $display("FAIL divzero[%0d]: q=%h r=%h lat=%0d expected q=%h r=%h lat=17",
                 i, gq, gr, lat, xq[i], xr[i]);
      else pass_cnt++;
`ifdef SDIV_DIVZERO_FLAG_EN
      total_cnt++;
      if (gz !== xz[i]) $display("FAIL divzero_flag[%0d]: got %b expected %b", i, gz, xz[i]);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_random();
    logic [15:0] a, gq, eq; logic [7:0] d, gr, er; logic gz; int lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 7))
        0: d = 8'h00;
        1: d = 8'h80;
        2: a = 16'h8000;
        3: d = 8'($urandom_range(1, 3));
        default: ;
      endcase
      model(a, d, eq, er);
      run_op(a, d, gq, gr, gz, lat);
      total_cnt++;
      if (gq !== eq || gr !== er || lat !== 17 || gz !== ((d == 8'h00) && flag_now() !== 1'bx && 1'b1 == 1'b1 ? flag_expect(d) : 1'b0))
        $display("FAIL random[%0d] ab=%h b=%h: q=%h r=%h lat=%0d flag=%b expected q=%h r=%h lat=17 flag=%b",
                 i, a, d, gq, gr, lat, gz, eq, er, flag_expect(d));
      else pass_cnt++;
    end
  endtask

  function automatic logic flag_expect(input logic [7:0] d);
`ifdef SDIV_DIVZERO_FLAG_EN
    return (d == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_ignore_busy();
    int lat;
    int extra;
    @(negedge clk);
    ab = 16'd100; b = 8'd7; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    ab = 16'h8000; b = 8'd3; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    lat = 4;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    total_cnt++;
    if (q !== 16'd14 || r !== 8'd2 || lat !== 17)
      $display("FAIL ignore_while_busy: q=%h r=%h lat=%0d expected q=000e r=02 lat=17", q, r, lat);
    else pass_cnt++;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL not_queued: saw %0d busy/done cycles expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [4];
    logic [7:0]  od [4];
    logic [15:0] eq; logic [7:0] er;
    int cyc, last, got, nset;
    for (int i = 0; i < 4; i++) begin
      oa[i] = 16'($urandom);
      od[i] = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    ab = oa[0]; b = od[0]; enable = 1'b1;
    nset = 1; cyc = 0; last = 0; got = 0;
    while (got < 4 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        model(oa[got], od[got], eq, er);
        total_cnt++;
        if (q !== eq || r !== er)
          $display("FAIL b2b_result[%0d]: q=%h r=%h expected q=%h r=%h", got, q, r, eq, er);
        else pass_cnt++;
        total_cnt++;
        if ((got == 0 && cyc !== 18) || (got > 0 && cyc - last !== 18))
          $display("FAIL b2b_spacing[%0d]: done at cycle %0d, previous %0d, expected spacing 18",
                   got, cyc, last);
        else pass_cnt++;
        last = cyc;
        got++;
        if (nset < 4) begin
          ab = oa[nset]; b = od[nset];
          nset++;
        end else enable = 1'b0;
      end
    end
    enable = 1'b0;
    total_cnt++;
    if (got !== 4) $display("FAIL b2b_count: got %0d results expected 4", got);
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] gq; logic [7:0] gr; logic gz; int lat;
    int seen;
    run_op(16'd100, 8'd7, gq, gr, gz, lat);
    @(negedge clk);
    ab = 16'h7FFF; b = 8'd3; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (q !== 16'h0 || r !== 8'h0 || busy !== 1'b0 || done !== 1'b0 || flag_now() !== 1'b0)
      $display("FAIL mid_reset: q=%h r=%h busy=%b done=%b expected all zero", q, r, busy, done);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL no_done_after_reset: saw %0d busy/done cycles expected 0", seen);
    else pass_cnt++;
    run_op(16'hFF9C, 8'd7, gq, gr, gz, lat);
    total_cnt++;
    if (gq !== 16'hFFF2 || gr !== 8'hFE || lat !== 17)
      $display("FAIL op_after_reset: q=%h r=%h lat=%0d expected q=fff2 r=fe lat=17", gq, gr, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_divzero();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
